// File: rtl/lut_port_arbiter_pkg.sv
// Shared accelerator definitions: LUT geometry, GELU lane count and the
// LUT port arbiter state encoding.
package lut_port_arbiter_pkg;

  localparam int LUT_ADDR_W     = 12;
  localparam int LUT_DATA_W     = 32;
  localparam int NUM_GELU_LANES = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_READY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// One-hot round-robin pick: the first set request at or after ptr wins,
// wrapping around. Also returns the binary index of the winner.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/lut_port_arbiter.sv
// Shares one LUT SRAM read port among the GELU lanes: round-robin grant,
// one-cycle response pipeline, and LUT load tracking (EMPTY/READY).
module lut_port_arbiter
  import lut_port_arbiter_pkg::*;
#(
  parameter int NUM_LANES = NUM_GELU_LANES,
  parameter int ADDR_W    = LUT_ADDR_W,
  parameter int DATA_W    = LUT_DATA_W
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_LANES-1:0]                  lane_req,
  input  logic [NUM_LANES-1:0][ADDR_W-1:0]      lane_addr,
  input  logic [NUM_LANES-1:0]                  lane_sign,
  output logic [NUM_LANES-1:0]                  lane_gnt,
  output logic [NUM_LANES-1:0]                  lane_rsp_valid,
  output logic [NUM_LANES-1:0][DATA_W/2-1:0]    lane_rsp_data,
  input  logic                                  cfg_wr_en,
  input  logic [ADDR_W-1:0]                     cfg_wr_addr,
  input  logic [DATA_W-1:0]                     cfg_wr_data,
  input  logic                                  cfg_done,
  output logic                                  sram_re,
  output logic [ADDR_W-1:0]                     sram_raddr,
  input  logic [DATA_W-1:0]                     sram_rdata,
  output logic                                  sram_we,
  output logic [ADDR_W-1:0]                     sram_waddr,
  output logic [DATA_W-1:0]                     sram_wdata,
  output logic                                  lut_ready,
  output logic                                  busy
);

  localparam int IDX_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int HALF_W = DATA_W / 2;

  arb_state_e                           state_q, state_d;
  logic                                 grant_en;
  logic [NUM_LANES-1:0]                 arb_req, gnt;
  logic [IDX_W-1:0]                     gnt_idx, rr_ptr, rsp_idx;
  logic                                 rsp_vld, rsp_sign;
  logic [HALF_W-1:0]                    rsp_half;
  logic [NUM_LANES-1:0][HALF_W-1:0]     data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // A write always invalidates the LUT, even alongside cfg_done.
  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    if (cfg_wr_en)     state_d = ST_EMPTY;
    else if (cfg_done) state_d = ST_READY;
    if (state_q == ST_READY && !cfg_wr_en) grant_en = 1'b1;
  end

  assign lut_ready = (state_q == ST_READY);
  assign arb_req   = grant_en ? lane_req : '0;

  rr_arbiter #(.N(NUM_LANES), .IDX_W(IDX_W)) u_rr (
    .req (arb_req),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign lane_gnt   = gnt;
  assign sram_re    = |gnt;
  assign sram_raddr = sram_re ? lane_addr[gnt_idx] : '0;

  assign sram_we    = cfg_wr_en;
  assign sram_waddr = cfg_wr_addr;
  assign sram_wdata = cfg_wr_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      rsp_vld  <= 1'b0;
      rsp_idx  <= '0;
      rsp_sign <= 1'b0;
    end else begin
      rsp_vld <= sram_re;
      if (sram_re) begin
        rsp_idx  <= gnt_idx;
        rsp_sign <= lane_sign[gnt_idx];
        rr_ptr   <= (gnt_idx == IDX_W'(NUM_LANES - 1)) ? '0 : gnt_idx + IDX_W'(1);
      end
    end
  end

  // SRAM data lands the cycle after the grant; it is shown directly on the
  // responding lane and captured so the lane keeps seeing it afterwards.
  assign rsp_half = rsp_sign ? sram_rdata[DATA_W-1:HALF_W] : sram_rdata[HALF_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      for (int l = 0; l < NUM_LANES; l++)
        if (rsp_vld && rsp_idx == IDX_W'(l)) data_q[l] <= rsp_half;
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic hit;
    assign hit               = rsp_vld && (rsp_idx == IDX_W'(l));
    assign lane_rsp_valid[l] = hit;
    assign lane_rsp_data[l]  = hit ? rsp_half : data_q[l];
  end

  assign busy = (|lane_req) | rsp_vld;

endmodule

// File: tb/tb_lut_port_arbiter.sv
// Bench for lut_port_arbiter: directed scenarios plus random traffic checked
// every cycle against a lane-level reference model and a behavioural SRAM.
module tb_lut_port_arbiter;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        lane_req;
  logic [3:0][11:0]  lane_addr;
  logic [3:0]        lane_sign;
  logic [3:0]        lane_gnt;
  logic [3:0]        lane_rsp_valid;
  logic [3:0][15:0]  lane_rsp_data;
  logic              cfg_wr_en;
  logic [11:0]       cfg_wr_addr;
  logic [31:0]       cfg_wr_data;
  logic              cfg_done;
  logic              sram_re;
  logic [11:0]       sram_raddr;
  logic [31:0]       sram_rdata;
  logic              sram_we;
  logic [11:0]       sram_waddr;
  logic [31:0]       sram_wdata;
  logic              lut_ready;
  logic              busy;

  lut_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .lane_req(lane_req), .lane_addr(lane_addr), .lane_sign(lane_sign),
    .lane_gnt(lane_gnt), .lane_rsp_valid(lane_rsp_valid), .lane_rsp_data(lane_rsp_data),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .cfg_done(cfg_done),
    .sram_re(sram_re), .sram_raddr(sram_raddr), .sram_rdata(sram_rdata),
    .sram_we(sram_we), .sram_waddr(sram_waddr), .sram_wdata(sram_wdata),
    .lut_ready(lut_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Registered SRAM, one-cycle read latency
  bit [31:0] mem [0:4095];
  always @(posedge clk) begin
    if (sram_we) mem[sram_waddr] <= sram_wdata;
    if (sram_re) sram_rdata <= mem[sram_raddr];
  end

  // Reference model state
  bit [31:0] ref_lut [0:4095];
  bit        m_ready;
  int        m_ptr;
  bit        m_rsp_vld;
  int        m_rsp_lane;
  bit [15:0] m_rsp_data;
  bit [15:0] m_lane_data [4];
  logic [3:0] last_gnt;
  logic [3:0] gnt_seen;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ready   = 0;
    m_ptr     = 0;
    m_rsp_vld = 0;
    for (int i = 0; i < 4; i++) m_lane_data[i] = '0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    lane_req  = '0;
    cfg_wr_en = 1'b0;
    cfg_done  = 1'b0;
    #1;
    chk("rst_gnt", lane_gnt, 0);
    chk("rst_rsp_valid", lane_rsp_valid, 0);
    chk("rst_rsp_data", lane_rsp_data, 0);
    chk("rst_sram_re", sram_re, 0);
    chk("rst_lut_ready", lut_ready, 0);
    chk("rst_busy", busy, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One clock: check outputs at the falling edge, then advance the model.
  task automatic cycle();
    int k;
    logic [3:0] eg;
    bit [31:0] w;
    @(negedge clk);
    k  = -1;
    eg = '0;
    if (m_ready && !cfg_wr_en)
      for (int i = 0; i < 4; i++)
        if (k < 0 && lane_req[(m_ptr + i) % 4]) k = (m_ptr + i) % 4;
    if (k >= 0) eg[k] = 1'b1;
    chk("gnt", lane_gnt, eg);
    chk("sram_re", sram_re, k >= 0);
    if (k >= 0) chk("sram_raddr", sram_raddr, lane_addr[k]);
    chk("rsp_valid", lane_rsp_valid, m_rsp_vld ? (4'b0001 << m_rsp_lane) : 4'b0000);
    if (m_rsp_vld) m_lane_data[m_rsp_lane] = m_rsp_data;
    for (int i = 0; i < 4; i++) chk("rsp_data", lane_rsp_data[i], m_lane_data[i]);
    chk("lut_ready", lut_ready, m_ready);
    chk("busy", busy, (|lane_req) || m_rsp_vld);
    chk("sram_we", sram_we, cfg_wr_en);
    last_gnt  = eg;
    m_rsp_vld = (k >= 0);
    if (k >= 0) begin
      m_rsp_lane = k;
      w          = ref_lut[lane_addr[k]];
      m_rsp_data = lane_sign[k] ? w[31:16] : w[15:0];
      m_ptr      = (k + 1) % 4;
    end
    if (cfg_wr_en) ref_lut[cfg_wr_addr] = cfg_wr_data;
    if (cfg_wr_en)     m_ready = 0;
    else if (cfg_done) m_ready = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; lane_req = '0; lane_addr = '0; lane_sign = '0;
    cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0; cfg_done = 1'b0;
    do_reset();

    // Unloaded LUT: requests stay pending
    lane_req = 4'b0001; lane_addr[0] = 12'd5; gnt_seen = '0;
    repeat (20) begin cycle(); gnt_seen |= last_gnt; end
    chk("empty_no_gnt", gnt_seen, 0);
    chk("empty_not_ready", lut_ready, 0);
    lane_req = '0;

    // Load and single lookup, upper half
    cfg_wr_en = 1; cfg_wr_addr = 12'd5; cfg_wr_data = 32'hBEEF1234; cycle();
    cfg_wr_en = 0; cfg_done = 1; cycle(); cfg_done = 0;
    lane_req = 4'b0100; lane_addr[2] = 12'd5; lane_sign[2] = 1'b1; cycle();
    chk("lane2_gnt", last_gnt, 4'b0100);
    chk("lane2_rsp_valid", lane_rsp_valid, 4'b0100);
    chk("lane2_rsp_beef", lane_rsp_data[2], 16'hBEEF);
    lane_req = 4'b1000; lane_addr[3] = 12'd5; lane_sign[3] = 1'b0; cycle();
    chk("lane3_gnt", last_gnt, 4'b1000);

    // All four lanes at once from pointer 0
    for (int i = 0; i < 4; i++) begin lane_addr[i] = 12'd5; lane_sign[i] = 1'b0; end
    lane_req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("rr4_gnt", last_gnt, 4'b0001 << i);
      chk("rr4_rsp_valid", lane_rsp_valid, 4'b0001 << i);
      chk("rr4_rsp_data", lane_rsp_data[i], 16'h1234);
      lane_req &= ~last_gnt;
    end
    cycle();

    // Two continuous requesters alternate
    lane_req = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("alt_gnt", last_gnt, (i % 2) ? 4'b1000 : 4'b0010);
    end
    lane_req = '0; cycle();

    // Write while lane 0 waits: no grant until a new cfg_done
    lane_req = 4'b0001; cfg_wr_en = 1; cfg_wr_addr = 12'd9; cfg_wr_data = $urandom; cycle();
    chk("wr_no_gnt", last_gnt, 0);
    chk("wr_ready_fall", lut_ready, 0);
    cfg_wr_en = 0; repeat (5) cycle();
    cfg_wr_en = 1; cfg_done = 1; cycle();
    chk("wr_beats_done", lut_ready, 0);
    cfg_wr_en = 0; cycle(); cfg_done = 0; cycle();
    chk("reload_gnt", last_gnt, 4'b0001);
    lane_req = '0; cycle();

    // Response in flight when a write begins
    lane_req = 4'b0010; lane_addr[1] = 12'd5; cycle();
    lane_req = '0; cfg_wr_en = 1; cfg_wr_addr = 12'd9; cfg_wr_data = $urandom; cycle();
    cfg_wr_en = 0; cfg_done = 1; cycle(); cfg_done = 0;

    // Random traffic over a preloaded LUT region
    for (int a = 0; a < 16; a++) begin
      cfg_wr_en = 1; cfg_wr_addr = 12'(a); cfg_wr_data = $urandom; cycle();
    end
    cfg_wr_en = 0; cfg_done = 1; cycle(); cfg_done = 0;
    repeat (300) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_req[i] && !last_gnt[i]) begin
          // pending request held unchanged
        end else if ($urandom_range(99, 0) < 50) begin
          lane_req[i]  = 1'b1;
          lane_addr[i] = 12'($urandom_range(15, 0));
          lane_sign[i] = 1'($urandom_range(1, 0));
        end else begin
          lane_req[i] = 1'b0;
        end
      end
      cfg_wr_en   = ($urandom_range(99, 0) < 4);
      cfg_wr_addr = 12'($urandom_range(15, 0));
      cfg_wr_data = $urandom;
      cfg_done    = ($urandom_range(99, 0) < 15);
      cycle();
    end
    lane_req = '0; cfg_wr_en = 0; cfg_done = 1; cycle(); cfg_done = 0; cycle();

    // Reset right after a grant discards the in-flight response
    lane_req = 4'b0010; lane_addr[1] = 12'd5; cycle();
    chk("pre_rst_gnt", last_gnt, 4'b0010);
    do_reset();
    repeat (5) cycle();
    chk("post_rst_ready", lut_ready, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lut_port_arbiter.md
LUT_PORT_ARBITER -- requirements
Module: lut_port_arbiter

Interface
REQ-001 Parameter NUM_LANES, default 4, number of GELU lanes sharing the LUT read port.
REQ-002 Parameter ADDR_W, default 12, LUT read address width.
REQ-003 Parameter DATA_W, default 32, LUT word width; upper half holds negative-input entry, lower half holds positive-input entry.
REQ-004 clk  input  1  clock; reset rst_n, asynchronous, active-low; clock clk.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 lane_req  input  NUM_LANES  per-lane lookup request; held until granted.
REQ-007 lane_addr  input  NUM_LANES x ADDR_W  per-lane LUT address; stable while lane_req high.
REQ-008 lane_sign  input  NUM_LANES  per-lane half-select: 1 = bits [31:16], 0 = bits [15:0].
REQ-009 lane_gnt  output  NUM_LANES  one-hot grant pulse, at most one bit per cycle.
REQ-010 lane_rsp_valid  output  NUM_LANES  one-hot response pulse, one cycle after the matching grant.
REQ-011 lane_rsp_data  output  NUM_LANES x DATA_W/2  selected half-word; updated only for the responding lane.
REQ-012 cfg_wr_en / cfg_wr_addr / cfg_wr_data  input  1 / ADDR_W / DATA_W  LUT load write from the ICB slave path.
REQ-013 cfg_done  input  1  one-cycle pulse marking the end of a LUT load.
REQ-014 sram_re / sram_raddr  output  1 / ADDR_W  LUT SRAM read port; sram_rdata input DATA_W, registered, 1-cycle latency.
REQ-015 sram_we / sram_waddr / sram_wdata  output  1 / ADDR_W / DATA_W  LUT SRAM write port, combinational pass-through of cfg_wr_*.
REQ-016 lut_ready  output  1  LUT contents valid; busy  output  1  a response is in flight or a request is pending.

Function
REQ-017 States: EMPTY (lut_ready=0), READY (lut_ready=1).
- EMPTY -> READY on cfg_done.
- READY -> EMPTY on any cfg_wr_en.
REQ-018 In EMPTY, or in any cycle with cfg_wr_en=1, no grant is issued; requests stay pending and no request is lost.
REQ-019 In READY with cfg_wr_en=0 and any lane_req set, exactly one lane is granted per cycle, chosen round-robin.
- Search starts at pointer rr_ptr.
- After a grant to lane k, rr_ptr becomes (k+1) mod NUM_LANES.
- rr_ptr is unchanged when no grant is issued.
REQ-020 On a grant to lane k, in the same cycle: sram_re=1, sram_raddr=lane_addr[k], lane_gnt[k]=1.
- lane_sign[k] and k are registered into the response pipeline.
REQ-021 Grant is combinational from registered state and the current lane_req, so a lane may drop lane_req the cycle after its grant.
- A lane that keeps lane_req high after a grant issues a new request.
REQ-022 One cycle after the grant, lane_rsp_valid[k]=1 and lane_rsp_data[k] = registered sign ? sram_rdata[31:16] : sram_rdata[15:0].
- lane_rsp_data[k] holds its value until the next response to lane k.
REQ-023 Throughput: one lookup per cycle sustained; 4 simultaneous requests complete in 4 consecutive grant cycles, responses in the 4 following cycles.
REQ-024 If cfg_done and cfg_wr_en are both high in the same cycle, cfg_wr_en wins: the state is EMPTY next cycle.
REQ-025 A response already in flight when cfg_wr_en rises still completes.
REQ-026 busy = |lane_req OR response pipeline valid.

Reset
REQ-027 On rst_n low, asynchronously:
- state = EMPTY, rr_ptr = 0.
- Response pipeline valid = 0.
- lane_gnt = 0, lane_rsp_valid = 0, lane_rsp_data = 0, sram_re = 0, lut_ready = 0, busy = 0.
REQ-028 Reset asserted mid-operation discards any in-flight response; no rsp_valid is produced for it after reset is released.
REQ-029 After reset the LUT is treated as unloaded; cfg_done is required before the first grant.

Structure
REQ-030 The shared accelerator package holds:
- the LUT geometry constants (LUT_ADDR_W=12, LUT_DATA_W=32);
- NUM_GELU_LANES=4;
- the arbiter state enum.
REQ-031 One sub-module, rr_arbiter (one-hot round-robin pick from a request vector and a pointer), is instantiated once; the rest is flat.

Verification
REQ-032 Reset, then lane_req=4'b0001 with no cfg_done -> no lane_gnt for 20 cycles, lut_ready=0.
REQ-033 Write addr 5 = 0xBEEF1234, then cfg_done, then lane 2 requests addr 5 sign 1:
- lane_gnt=4'b0100;
- next cycle lane_rsp_valid=4'b0100, lane_rsp_data[2]=0xBEEF.
REQ-034 All 4 lanes request in the same cycle with rr_ptr=0, with addr 5 and sign 0 for each:
- grants 0,1,2,3 in consecutive cycles;
- each response = 0x1234 one cycle after its grant.
REQ-035 Lanes 1 and 3 request continuously -> grants alternate 1,3,1,3.
REQ-036 cfg_wr_en pulse while lane 0 requests:
- no grant in that cycle or afterward until a new cfg_done;
- lut_ready falls next cycle.
REQ-037 Assert rst_n low in the cycle after a grant to lane 1 -> no lane_rsp_valid after release, and all outputs are 0.
